// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: streams OUT_W-bit stimulus vectors built from a 32-bit LCG
// (or counter / constant patterns) under start/busy/done control, with a
// valid/ready output handshake.
module lcg_stim_gen #(
  parameter int unsigned OUT_W   = 261,
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] LCG_MUL = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC = 32'h3039
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int unsigned NW = (OUT_W + 31) / 32;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        lcg_q, lcg_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;

  // Vector generator inputs and results
  logic [31:0]        gen_seed;
  logic [1:0]         gen_mode;
  logic [CNT_W-1:0]   gen_idx;
  logic [31:0]        gen_s;
  logic [31:0]        gen_idx32;
  logic [NW*32-1:0]   gen_full;
  logic [31:0]        gen_next;
  logic [CNT_W-1:0]   cnt_inc;

  assign cnt_inc = vec_cnt_q + CNT_W'(1);

  // Select generator source: the start inputs in IDLE, the running state otherwise.
  always_comb begin
    gen_seed = lcg_q;
    gen_mode = mode_q;
    gen_idx  = cnt_inc;
    if (state_q == StIdle) begin
      gen_seed = seed;
      gen_mode = mode;
      gen_idx  = '0;
    end
  end

  // Build one vector; word k is the LCG state after step k+1.
  always_comb begin
    gen_s     = gen_seed;
    gen_idx32 = 32'(gen_idx);
    gen_full  = '0;
    gen_next  = gen_seed;
    unique case (gen_mode)
      2'd0: begin
        for (int k = 0; k < NW; k++) begin
          gen_s = gen_s * LCG_MUL + LCG_INC;
          gen_full[32*k +: 32] = gen_s;
        end
        gen_next = gen_s;
      end
      2'd1: gen_full = {NW{gen_idx32}};
      2'd2: gen_full = '0;
      2'd3: gen_full = '1;
    endcase
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    lcg_d     = lcg_q;
    cycles_d  = cycles_q;
    mode_d    = mode_q;
    vec_cnt_d = vec_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cycles_d  = cycles;
          mode_d    = mode;
          vec_cnt_d = '0;
          lcg_d     = seed;
          if (cycles != '0) begin
            lcg_d   = gen_next;
            data_d  = gen_full[OUT_W-1:0];
            valid_d = 1'b1;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (valid_q && out_ready) begin
          vec_cnt_d = cnt_inc;
          if (cnt_inc == cycles_q) begin
            valid_d = 1'b0;
            state_d = StDone;
          end else begin
            data_d = gen_full[OUT_W-1:0];
            lcg_d  = gen_next;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lcg_q     <= '0;
      cycles_q  <= '0;
      mode_q    <= '0;
      vec_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lcg_q     <= lcg_d;
      cycles_q  <= cycles_d;
      mode_q    <= mode_d;
      vec_cnt_q <= vec_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign vec_cnt   = vec_cnt_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Self-checking bench for lcg_stim_gen against a word-list LCG reference model.
module tb_lcg_stim_gen;

  localparam int unsigned OUT_W = 261;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned NW    = (OUT_W + 31) / 32;
  localparam int          W     = OUT_W;
  localparam logic [31:0] MUL   = 32'h41C64E6D;
  localparam logic [31:0] INC   = 32'h3039;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [CNT_W-1:0] cycles;
  logic [1:0]       mode;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W-1:0] first_vec;

  lcg_stim_gen #(
    .OUT_W  (OUT_W),
    .CNT_W  (CNT_W),
    .LCG_MUL(MUL),
    .LCG_INC(INC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .cycles   (cycles),
    .mode     (mode),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .vec_cnt  (vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] got,
                          input logic [OUT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: list of NW words per vector, then packed bit by bit.
  function automatic logic [OUT_W-1:0] model_vec(input logic [1:0] md, input int unsigned idx,
                                                 input logic [31:0] st_in,
                                                 output logic [31:0] st_out);
    logic [31:0] words[NW];
    logic [31:0] st;
    logic [OUT_W-1:0] v;
    st = st_in;
    for (int k = 0; k < NW; k++) begin
      case (md)
        2'd0: begin
          st = st * MUL + INC;
          words[k] = st;
        end
        2'd1: words[k] = idx;
        2'd2: words[k] = 32'h0;
        default: words[k] = 32'hFFFF_FFFF;
      endcase
    end
    for (int b = 0; b < OUT_W; b++) v[b] = words[b / 32][b % 32];
    st_out = st;
    return v;
  endfunction

  // rmode: 0 = always ready, 1 = random ready, 2 = stalled for 5 cycles then ready.
  task automatic do_run(input logic [31:0] sd, input int unsigned n, input logic [1:0] md,
                        input int rmode, input bit restart);
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] prev;
    logic [31:0] st, st_nxt;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    bit r;
    int hs = 0;
    int cyc = 0;
    st = sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_vec(md, i, st, st_nxt));
      st = st_nxt;
    end
    seed = sd; cycles = CNT_W'(n); mode = md; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; seed = $urandom; cycles = CNT_W'($urandom); mode = 2'($urandom);
    check_eq("lat_valid", W'(out_valid), W'(n != 0));
    check_eq("lat_busy", W'(busy), W'(n != 0));
    check_eq("lat_done", W'(done), W'(n == 0));
    check_eq("start_cnt", W'(vec_cnt), W'(0));
    first_vec = out_data;
    while (!fin && cyc < 40 * int'(n) + 20) begin
      if (done) begin
        fin = 1'b1;
        check_eq("done_cnt", W'(vec_cnt), W'(n));
        check_eq("done_busy", W'(busy), W'(0));
        check_eq("done_valid", W'(out_valid), W'(0));
      end else begin
        if (stalled) begin
          check_eq("stall_valid", W'(out_valid), W'(1));
          check_eq("stall_data", out_data, prev);
        end
        start = restart && (cyc == 2);
        case (rmode)
          0: r = 1'b1;
          1: r = 1'($urandom_range(0, 1));
          default: r = (cyc >= 5);
        endcase
        out_ready = r;
        stalled = out_valid && !r;
        prev = out_data;
        if (out_valid && r) begin
          hs++;
          if (exp_q.size() == 0) check_eq("extra_vec", W'(1), W'(0));
          else check_eq("vec_data", out_data, exp_q.pop_front());
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    check_eq("run_timeout", W'(fin), W'(1));
    check_eq("handshakes", W'(hs), W'(n));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("post_done", W'(done), W'(0));
      check_eq("post_busy", W'(busy), W'(0));
      check_eq("post_cnt", W'(vec_cnt), W'(n));
    end
  endtask

  initial begin
    logic [31:0] st_dummy;
    logic [31:0] rs;
    rst = 1'b1; start = 1'b0; seed = '0; cycles = '0; mode = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_data", out_data, W'(0));
    check_eq("rst_valid", W'(out_valid), W'(0));
    check_eq("rst_busy", W'(busy), W'(0));
    check_eq("rst_done", W'(done), W'(0));
    check_eq("rst_cnt", W'(vec_cnt), W'(0));

    // Seed 0, one vector
    do_run(32'd0, 1, 2'd0, 0, 1'b0);
    check_eq("s0_w0", W'(first_vec[31:0]), W'(32'h0000_3039));
    check_eq("s0_w1", W'(first_vec[63:32]), W'(32'hD3DC_167E));

    // Seed 1, stalled start
    do_run(32'd1, 3, 2'd0, 2, 1'b0);
    check_eq("s1_w0", W'(first_vec[31:0]), W'(32'h41C6_7EA6));

    // Counter mode
    do_run(32'hDEAD_BEEF, 4, 2'd1, 0, 1'b0);
    check_eq("cnt_top", W'(first_vec[260:256]), W'(0));

    // Zero-length run
    do_run(32'h1234_5678, 0, 2'd0, 0, 1'b0);

    // start pulsed again mid-run
    do_run(32'hCAFE_F00D, 5, 2'd0, 0, 1'b1);

    // Constant modes
    do_run($urandom, 3, 2'd2, 1, 1'b0);
    do_run($urandom, 3, 2'd3, 1, 1'b0);

    // Randomized runs
    repeat (8) do_run($urandom, $urandom_range(1, 12), 2'($urandom_range(0, 3)), 1, 1'b0);

    // Reset mid-run after 2 of 6 vectors
    rs = $urandom;
    seed = rs; cycles = CNT_W'(6); mode = 2'd0; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("pre_rst_cnt", W'(vec_cnt), W'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    check_eq("mid_rst_valid", W'(out_valid), W'(0));
    check_eq("mid_rst_busy", W'(busy), W'(0));
    check_eq("mid_rst_cnt", W'(vec_cnt), W'(0));
    check_eq("mid_rst_data", out_data, W'(0));
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_rst_done", W'(done), W'(0));
      @(posedge clk); #1;
    end
    do_run(rs, 1, 2'd0, 0, 1'b0);
    check_eq("replay_v0", first_vec, model_vec(2'd0, 0, rs, st_dummy));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
